// File: rtl/dcache_load_unit.sv
// MEM-stage load unit: waits for the D-cache word, extracts and extends the
// addressed byte/half/word, and holds the result while writeback is stalled.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module dcache_load_unit (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_req,
   input  logic [2:0]              funct3,
   input  logic [1:0]              addr_low,
   input  logic [`DATA_SIZE-1:0]   Dcache_out,
   input  logic                    D_wait,
   input  logic                    stall_WB,
   output logic [`DATA_SIZE-1:0]   load_data,
   output logic                    load_valid,
   output logic                    stall_MEM,
   output logic                    load_err
);

   localparam int DW = `DATA_SIZE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [2:0]  f3_r;
   logic [1:0]  al_r;
   logic        legal_s;
   logic        capture_s;
   logic        valid_next_s;
   logic        err_next_s;
   logic        stall_s;

   function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] al);
      logic ok;
      case (f3)
         3'b000, 3'b100: ok = 1'b1;
         3'b001, 3'b101: ok = (al[0] == 1'b0);
         3'b010:         ok = (al == 2'b00);
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [DW-1:0] extract_load(input logic [2:0] f3,
                                                  input logic [1:0] al,
                                                  input logic [DW-1:0] word);
      logic [7:0]    byte_v;
      logic [15:0]   half_v;
      logic [DW-1:0] res;
      byte_v = word[{al, 3'b000} +: 8];
      half_v = word[{al[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  res = {{(DW-8){byte_v[7]}}, byte_v};
         3'b001:  res = {{(DW-16){half_v[15]}}, half_v};
         3'b100:  res = {{(DW-8){1'b0}}, byte_v};
         3'b101:  res = {{(DW-16){1'b0}}, half_v};
         3'b010:  res = word;
         default: res = {DW{1'b0}};
      endcase
      return res;
   endfunction

   assign legal_s   = is_legal(funct3, addr_low);
   assign stall_MEM = stall_s;

   // Next-state, stall and result-register control for the load FSM
   always_comb begin
      next_state_s = state_r;
      stall_s      = 1'b0;
      capture_s    = 1'b0;
      valid_next_s = 1'b0;
      err_next_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (load_req) begin
               if (legal_s) begin
                  next_state_s = WAIT;
                  stall_s      = 1'b1;
               end else begin
                  err_next_s = 1'b1;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         WAIT: begin
            if (D_wait) begin
               stall_s = 1'b1;
            end else begin
               capture_s    = 1'b1;
               valid_next_s = 1'b1;
               next_state_s = stall_WB ? HOLD : IDLE;
            end
         end
         HOLD: begin
            stall_s = 1'b1;
            if (stall_WB) begin
               valid_next_s = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, latched request fields and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         f3_r       <= 3'b000;
         al_r       <= 2'b00;
         load_data  <= {DW{1'b0}};
         load_valid <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         load_valid <= valid_next_s;
         load_err   <= err_next_s;
         if (state_r == IDLE && load_req && legal_s) begin
            f3_r <= funct3;
            al_r <= addr_low;
         end
         if (capture_s) begin
            load_data <= extract_load(f3_r, al_r, Dcache_out);
         end
      end
   end

endmodule

// File: doc/dcache_load_unit.md
DCACHE_LOAD_UNIT -- requirements
Module: dcache_load_unit

Interface
REQ-001 clk  input  1  Core clock; all state changes on rising edge.
REQ-002 rst  input  1  Reset; asynchronous assertion, active-low (rst=0 resets).
REQ-003 load_req  input  1  MEM-stage load valid this cycle.
REQ-004 funct3  input  3  Load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-005 addr_low  input  2  Byte offset, effective address bits [1:0].
REQ-006 Dcache_out  input  `data_size  Word read from D-cache, little-endian.
REQ-007 D_wait  input  1  D-cache busy; Dcache_out is valid only when D_wait=0.
REQ-008 stall_WB  input  1  Downstream stall; WB cannot take a result this cycle.
REQ-009 load_data  output  `data_size  Aligned, extended load result; registered.
REQ-010 load_valid  output  1  load_data valid; registered.
REQ-011 stall_MEM  output  1  Hold MEM stage; combinational.
REQ-012 load_err  output  1  One-cycle pulse on misaligned or unsupported load; registered.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and HOLD.
- Legal load: LB/LBU any offset, LH/LHU with addr_low[0]=0, LW with addr_low=00.
- IDLE + load_req + legal: latch funct3 and addr_low; next state WAIT.
- IDLE + load_req + illegal: load_err=1 next cycle only; stay IDLE; no cache wait.
- IDLE + load_req=0: stay IDLE.
REQ-014 WAIT + D_wait=1 SHALL stay in WAIT, with no capture.
REQ-015 WAIT + D_wait=0 SHALL capture the extracted Dcache_out into load_data and set load_valid=1 next cycle.
- Next state HOLD if stall_WB=1, else IDLE.
REQ-016 HOLD SHALL keep load_data and load_valid=1 stable while stall_WB=1, then return to IDLE on the first cycle with stall_WB=0.
REQ-017 load_valid SHALL be 1 for exactly one cycle per load when stall_WB=0, and is otherwise cleared on the cycle after leaving HOLD.
REQ-018 stall_MEM SHALL be 1 when any of these hold:
- IDLE with load_req and a legal load;
- WAIT with D_wait=1;
- HOLD.
It is 0 otherwise, so the pipeline advances on the capture edge.
REQ-019 load_req in WAIT or HOLD SHALL be ignored (it is covered by stall_MEM=1).
REQ-020 Extraction SHALL work as follows:
- byte = Dcache_out[8*addr_low+7 : 8*addr_low].
- half = Dcache_out[16*addr_low[1]+15 : 16*addr_low[1]].
- LB/LH sign-extend to `data_size; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-021 Minimum latency SHALL be load_req cycle N (IDLE), capture cycle N+1 (WAIT, D_wait=0), load_valid=1 in cycle N+2.
REQ-022 Each extra D_wait=1 cycle in WAIT SHALL add exactly one cycle of latency.
REQ-023 Unsupported funct3 (011, 110, 111) SHALL be treated as illegal (load_err).
REQ-024 load_err SHALL be 0 in every cycle that does not follow an illegal request in IDLE.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, load_data=0, load_valid=0, load_err=0, and latched funct3/addr_low=0, regardless of clk.
REQ-026 Reset asserted during WAIT or HOLD SHALL drop the in-flight load with no load_valid pulse after release.
REQ-027 After rst returns to 1, the first load_req SHALL be accepted on the next rising edge.

Verification
REQ-028 LB, addr_low=11, Dcache_out=0x80FF_1234, D_wait=0 -> load_data=0xFFFF_FF80, load_valid=1 exactly at N+2, stall_MEM=1 at N only.
REQ-029 LHU, addr_low=10, Dcache_out=0x9ABC_0001, D_wait=1 for 3 cycles -> stall_MEM=1 for N..N+3, load_data=0x0000_9ABC, load_valid at N+5.
REQ-030 LW, addr_low=01 -> load_err=1 at N+1 only, stall_MEM=0 at N, state stays IDLE, load_valid stays 0.
REQ-031 LW of 0x1234_5678 with stall_WB=1 for 4 cycles from the capture cycle -> load_valid and load_data=0x1234_5678 held all 4 cycles, stall_MEM=1 throughout, load_req ignored; IDLE after stall_WB drops.
REQ-032 rst=0 pulsed mid-WAIT, then D_wait=0 -> outputs 0 asynchronously, no load_valid after release; next LH addr_low=00 of 0x0000_8001 -> load_data=0xFFFF_8001.
REQ-033 Back-to-back LBU loads at offsets 00, 01, 10, 11 of 0xA1B2_C3D4, D_wait=0 -> results 0xD4, 0xC3, 0xB2, 0xA1 on successive load_valid pulses.
